// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM state type and small op-decoding helpers.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    // Even codes are the signed flavours of each operation.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // rem_in < divisor, so diff lies in [-divisor, divisor-1]: the top bit is the borrow.
        if (diff[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide feeding the CPU High/Low
// registers; one result bit per cycle on unsigned magnitudes, sign fixed at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    state_t state, state_next;

    logic [1:0]       op_r;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [CNT_W-1:0] cnt;
    logic             res_neg;
    logic             rem_neg;
    logic             dz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             in_div_zero;
    logic             last_step;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   div_rem, div_quo;
    logic [WIDTH-1:0]   rem_fin, quo_fin;

    // Operand conditioning at acceptance time.
    always_comb begin
        a_neg       = is_signed_op(op) & a[WIDTH-1];
        b_neg       = is_signed_op(op) & b[WIDTH-1];
        abs_a       = a_neg ? (~a + 1'b1) : a;
        abs_b       = b_neg ? (~b + 1'b1) : b;
        in_div_zero = is_div_op(op) & (b == '0);
    end

    assign last_step = (cnt == CNT_W'(1));

    // Multiply: {work_hi, work_lo} is the product register, work_lo starts as the multiplier.
    assign add_sum  = work_lo[0] ? ({1'b0, work_hi} + {1'b0, opnd_b}) : {1'b0, work_hi};
    assign prod_nxt = {add_sum, work_lo[WIDTH-1:1]};
    assign prod_fin = res_neg ? (~prod_nxt + 1'b1) : prod_nxt;

    // Divide: work_hi is the partial remainder, work_lo the dividend/quotient shift register.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (work_hi),
        .quo_in  (work_lo),
        .divisor (opnd_b),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    assign quo_fin = res_neg ? (~div_quo + 1'b1) : div_quo;
    assign rem_fin = rem_neg ? (~div_rem + 1'b1) : div_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = in_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '0;
            opnd_b  <= '0;
            work_hi <= '0;
            work_lo <= '0;
            cnt     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz_r    <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        opnd_b  <= abs_b;
                        work_hi <= '0;
                        work_lo <= abs_a;
                        cnt     <= CNT_W'(WIDTH);
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        dz_r    <= in_div_zero;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (is_div_op(op_r)) begin
                        work_hi <= div_rem;
                        work_lo <= div_quo;
                    end else begin
                        {work_hi, work_lo} <= prod_nxt;
                    end
                    if (last_step) begin
                        if (is_div_op(op_r)) begin
                            hi_r <= rem_fin;
                            lo_r <= quo_fin;
                        end else begin
                            {hi_r, lo_r} <= prod_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign div_zero  = (state == DONE) & dz_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a driver pushes hand-computed results into a
// scoreboard queue, and a monitor compares them whenever done is seen.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [1:0]    state_dbg;

    logic [2*W:0]  exp_q[$];
    string         name_q[$];

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [W-1:0]  prev_hi = '0;
    logic [W-1:0]  prev_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // driver: issue one operation and time it from the accepting edge
    task automatic issue(input string nm, input logic [1:0] o,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                         input logic e_dz, input bit hold);
        int cycles;
        int exp_lat;
        exp_q.push_back({e_dz, e_hi, e_lo});
        name_q.push_back(nm);
        exp_lat = e_dz ? 1 : W + 1;
        @(negedge clk);
        check({nm, " busy_before"}, 64'(busy), 64'(1'b0));
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom_range(0, 3));
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) check({nm, " busy_after_start"}, 64'(busy), 64'(1'b1));
            if (done) break;
            if (cycles == 16) begin
                check({nm, " hi_hold_mid"}, 64'(hi), 64'(prev_hi));
                check({nm, " lo_hold_mid"}, 64'(lo), 64'(prev_lo));
            end
            if (cycles >= 100) break;
        end
        if (hold) start = 1'b0;
        check({nm, " latency"}, 64'(cycles), 64'(exp_lat));
        prev_hi = e_hi;
        prev_lo = e_lo;
        if (hold) begin
            repeat (5) @(negedge clk);
            check({nm, " idle_after_hold"}, 64'(busy), 64'(1'b0));
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [2*W:0] e;
        string        nm;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation");
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
                    check({nm, " lo"}, 64'(lo), 64'(e[W-1:0]));
                    check({nm, " div_zero"}, 64'(div_zero), 64'(e[2*W]));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'(1'b0));
        check("reset done", 64'(done), 64'(1'b0));
        check("reset div_zero", 64'(div_zero), 64'(1'b0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset state", 64'(state_dbg), 64'(0));
        reset = 1'b0;

        issue("mult_m3x7",       2'd0, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        issue("multu_max_x2",    2'd1, 32'hFFFFFFFF, 32'd2,       32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue("mult_m1x2",       2'd0, 32'hFFFFFFFF, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue("mult_minxmin",    2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        issue("mult_m5xm6",      2'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, 1'b0);
        issue("multu_2p16sq",    2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
        issue("div_m7_2",        2'd2, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue("div_7_m2",        2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue("div_min_m1",      2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        issue("divu_max_1",      2'd3, 32'hFFFFFFFF, 32'd1,       32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue("divu_100_7",      2'd3, 32'd100,      32'd7,       32'h00000002, 32'h0000000E, 1'b0, 1'b0);
        issue("divu_7_2",        2'd3, 32'd7,        32'd2,       32'h00000001, 32'h00000003, 1'b0, 1'b0);
        issue("divu_7_0",        2'd3, 32'd7,        32'd0,       32'h00000001, 32'h00000003, 1'b1, 1'b0);
        issue("div_m1_0",        2'd2, 32'hFFFFFFFF, 32'd0,       32'h00000001, 32'h00000003, 1'b1, 1'b0);

        // abort a multiply with reset ten edges into the calculation
        @(negedge clk);
        op    = 2'd0;
        a     = 32'd3;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'(1'b0));
        check("abort done", 64'(done), 64'(1'b0));
        check("abort hi", 64'(hi), 64'(0));
        check("abort lo", 64'(lo), 64'(0));
        check("abort state", 64'(state_dbg), 64'(0));
        prev_hi = '0;
        prev_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue("mult_6x7_post_reset", 2'd0, 32'd6,   32'd7, 32'h00000000, 32'h0000002A, 1'b0, 1'b0);
        issue("divu_held_start",     2'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 1'b1);
        issue("divu_5_0",            2'd3, 32'd5,   32'd0, 32'h00000002, 32'h0000000E, 1'b1, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
